// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - state, opcode and write-select encodings shared by the sequencing control unit
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_MEMORY    = 3'b011,
        ST_WRITEBACK = 3'b100,
        ST_HALT      = 3'b101,
        ST_STEP_WAIT = 3'b110
    } cu_state_e;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_AND   = 3'b001;
    localparam logic [2:0] OP_NOT   = 3'b010;
    localparam logic [2:0] OP_LOADI = 3'b011;
    localparam logic [2:0] OP_LD    = 3'b100;
    localparam logic [2:0] OP_ST    = 3'b101;
    localparam logic [2:0] OP_JZ    = 3'b110;
    localparam logic [2:0] OP_HLT   = 3'b111;

    localparam logic [1:0] WSEL_ALU = 2'b00;
    localparam logic [1:0] WSEL_IMM = 2'b01;
    localparam logic [1:0] WSEL_MEM = 2'b10;

    // op occupies the top OP_W bits; rd and rs follow immediately below it
    localparam int OP_W = 3;

    function automatic int reg_addr_w(input int num_regs);
        return (num_regs <= 2) ? 1 : $clog2(num_regs);
    endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// rtl/cu_wait_timer.sv - memory wait-state counter flagging the cycle that exhausts WAIT_MAX
module cu_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [CW-1:0] LAST = CW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed wait cycles, so LAST marks the WAIT_MAX-th waiting cycle
    assign timeout = (WAIT_MAX > 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/seq_control_unit.sv
// rtl/seq_control_unit.sv - multi-cycle CPU sequencer with memory wait timeout; CU_SINGLE_STEP_EN adds step gating
module seq_control_unit
    import cu_pkg::*;
#(
    parameter int IW       = 8,
    parameter int NUM_REGS = 2,
    parameter int IMW      = 4,
    parameter int WAIT_MAX = 15,
    localparam int RW      = reg_addr_w(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] instr,
    input  logic          zf,
    input  logic          mem_ready,
`ifdef CU_SINGLE_STEP_EN
    input  logic          step,
`endif
    output logic [2:0]    state,
    output logic          pc_we,
    output logic          pc_sel,
    output logic          ir_we,
    output logic          mem_req,
    output logic          mem_we,
    output logic          addr_sel,
    output logic [2:0]    alu_opcode,
    output logic          alu_we,
    output logic          zf_we,
    output logic [RW-1:0] rf_raddr_a,
    output logic [RW-1:0] rf_raddr_b,
    output logic          rf_we,
    output logic [RW-1:0] rf_waddr,
    output logic [1:0]    rf_wsel,
    output logic          halt,
    output logic          fault
);

    cu_state_e state_q, state_d, done_state;
    logic      fault_q, fault_d;
    logic      waiting, timeout;

    logic [OP_W-1:0] op;
    logic [RW-1:0]   rd, rs;
    logic [IMW-1:0]  imm;
    logic            unused_fields;

    assign op  = instr[IW-1 -: OP_W];
    assign rd  = instr[IW-1-OP_W -: RW];
    assign rs  = instr[IW-1-OP_W-RW -: RW];
    // the immediate feeds the PC adder and address path, not the sequencer
    assign imm = instr[IMW-1:0];
    assign unused_fields = ^{imm, instr};

`ifdef CU_SINGLE_STEP_EN
    assign done_state = step ? ST_FETCH : ST_STEP_WAIT;
`else
    assign done_state = ST_FETCH;
`endif

    assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEMORY);

    cu_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (!waiting || mem_ready),
        .en      (waiting && !mem_ready),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        state      = 3'b000;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        ir_we      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        alu_opcode = 3'b000;
        alu_we     = 1'b0;
        zf_we      = 1'b0;
        rf_raddr_a = '0;
        rf_raddr_b = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wsel    = WSEL_ALU;
        halt       = 1'b0;
        fault      = 1'b0;
        // gating on reset keeps a mid-access reset from leaving mem_req/mem_we asserted
        if (reset) begin
            state = state_q;
            fault = fault_q;
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = ST_DECODE;
                    end else if (timeout) begin
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end
                end
                ST_DECODE: begin
                    rf_raddr_a = rd;
                    rf_raddr_b = rs;
                    state_d    = (op == OP_HLT) ? ST_HALT : ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    case (op)
                        OP_ADD, OP_AND, OP_NOT: begin
                            alu_opcode = op;
                            alu_we     = 1'b1;
                            zf_we      = 1'b1;
                            state_d    = ST_WRITEBACK;
                        end
                        OP_LOADI:     state_d = ST_WRITEBACK;
                        OP_LD, OP_ST: state_d = ST_MEMORY;
                        OP_JZ: begin
                            pc_we   = zf;
                            pc_sel  = zf;
                            state_d = done_state;
                        end
                        default:      state_d = ST_HALT;
                    endcase
                end
                ST_MEMORY: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (op == OP_ST);
                    if (mem_ready) begin
                        state_d = (op == OP_LD) ? ST_WRITEBACK : done_state;
                    end else if (timeout) begin
                        state_d = ST_HALT;
                        fault_d = 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    rf_we    = 1'b1;
                    rf_waddr = rd;
                    case (op)
                        OP_LOADI: rf_wsel = WSEL_IMM;
                        OP_LD:    rf_wsel = WSEL_MEM;
                        default:  rf_wsel = WSEL_ALU;
                    endcase
                    state_d = done_state;
                end
                ST_HALT:      halt    = 1'b1;
                ST_STEP_WAIT: state_d = done_state;
                default:      state_d = ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_control_unit.sv
// tb/tb_seq_control_unit.sv - table-driven bench for seq_control_unit plus timeout, reset and step sequences
module tb_seq_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instr;
    logic       zf;
    logic       mem_ready;
    logic       step;
    logic [2:0] state;
    logic       pc_we, pc_sel, ir_we, mem_req, mem_we, addr_sel;
    logic [2:0] alu_opcode;
    logic       alu_we, zf_we;
    logic       rf_raddr_a, rf_raddr_b, rf_we, rf_waddr;
    logic [1:0] rf_wsel;
    logic       halt, fault;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seq_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .zf         (zf),
        .mem_ready  (mem_ready),
`ifdef CU_SINGLE_STEP_EN
        .step       (step),
`endif
        .state      (state),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .ir_we      (ir_we),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .addr_sel   (addr_sel),
        .alu_opcode (alu_opcode),
        .alu_we     (alu_we),
        .zf_we      (zf_we),
        .rf_raddr_a (rf_raddr_a),
        .rf_raddr_b (rf_raddr_b),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wsel    (rf_wsel),
        .halt       (halt),
        .fault      (fault)
    );

    typedef struct packed {
        logic [7:0]  instr;
        logic        zf;
        logic        mr;
        logic [21:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [21:0] outs();
        return {state, pc_we, pc_sel, ir_we, mem_req, mem_we, addr_sel, alu_opcode,
                alu_we, zf_we, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wsel, halt, fault};
    endfunction

    task automatic add(input logic [7:0] i, input logic z, input logic m, input logic [2:0] st,
                       input logic pcw, input logic pcs, input logic irw, input logic mreq,
                       input logic mwe, input logic asel, input logic [2:0] aop, input logic awe,
                       input logic zwe, input logic ra, input logic rb, input logic rfwe,
                       input logic wa, input logic [1:0] ws, input logic hlt, input logic flt);
        vec_t v;
        v.instr = i;
        v.zf    = z;
        v.mr    = m;
        v.exp   = {st, pcw, pcs, irw, mreq, mwe, asel, aop, awe, zwe, ra, rb, rfwe, wa, ws, hlt, flt};
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s act=%h exp=%h", nm, act, exp);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        // in  zf mr st pcw pcs irw mrq mwe asl aop awe zwe ra rb rfw wa ws h f
        add(8'h10,0,1, 0, 1,0,1,1,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);   // ADD R1,R0
        add(8'h10,0,0, 1, 0,0,0,0,0,0, 3'd0, 0,0, 1,0, 0,0, 2'd0, 0,0);
        add(8'h10,0,0, 2, 0,0,0,0,0,0, 3'd0, 1,1, 0,0, 0,0, 2'd0, 0,0);
        add(8'h10,0,0, 4, 0,0,0,0,0,0, 3'd0, 0,0, 0,0, 1,1, 2'd0, 0,0);
        add(8'h28,0,1, 0, 1,0,1,1,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);   // AND R0,R1
        add(8'h28,0,0, 1, 0,0,0,0,0,0, 3'd0, 0,0, 0,1, 0,0, 2'd0, 0,0);
        add(8'h28,0,0, 2, 0,0,0,0,0,0, 3'd1, 1,1, 0,0, 0,0, 2'd0, 0,0);
        add(8'h28,0,0, 4, 0,0,0,0,0,0, 3'd0, 0,0, 0,0, 1,0, 2'd0, 0,0);
        add(8'h50,0,0, 0, 0,0,0,1,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);   // NOT R1, fetch waits
        add(8'h50,0,0, 0, 0,0,0,1,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);
        add(8'h50,0,1, 0, 1,0,1,1,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);
        add(8'h50,0,0, 1, 0,0,0,0,0,0, 3'd0, 0,0, 1,0, 0,0, 2'd0, 0,0);
        add(8'h50,0,0, 2, 0,0,0,0,0,0, 3'd2, 1,1, 0,0, 0,0, 2'd0, 0,0);
        add(8'h50,0,0, 4, 0,0,0,0,0,0, 3'd0, 0,0, 0,0, 1,1, 2'd0, 0,0);
        add(8'h75,0,1, 0, 1,0,1,1,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);   // LOADI R1,5
        add(8'h75,0,0, 1, 0,0,0,0,0,0, 3'd0, 0,0, 1,0, 0,0, 2'd0, 0,0);
        add(8'h75,0,0, 2, 0,0,0,0,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);
        add(8'h75,0,0, 4, 0,0,0,0,0,0, 3'd0, 0,0, 0,0, 1,1, 2'd1, 0,0);
        add(8'h8A,0,1, 0, 1,0,1,1,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);   // LD R0,[R1+2], 3 waits
        add(8'h8A,0,0, 1, 0,0,0,0,0,0, 3'd0, 0,0, 0,1, 0,0, 2'd0, 0,0);
        add(8'h8A,0,0, 2, 0,0,0,0,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);
        add(8'h8A,0,0, 3, 0,0,0,1,0,1, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);
        add(8'h8A,0,0, 3, 0,0,0,1,0,1, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);
        add(8'h8A,0,0, 3, 0,0,0,1,0,1, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);
        add(8'h8A,0,1, 3, 0,0,0,1,0,1, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);
        add(8'h8A,0,0, 4, 0,0,0,0,0,0, 3'd0, 0,0, 0,0, 1,0, 2'd2, 0,0);
        add(8'hB3,0,1, 0, 1,0,1,1,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);   // ST R1,[R0+3]
        add(8'hB3,0,0, 1, 0,0,0,0,0,0, 3'd0, 0,0, 1,0, 0,0, 2'd0, 0,0);
        add(8'hB3,0,0, 2, 0,0,0,0,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);
        add(8'hB3,0,1, 3, 0,0,0,1,1,1, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);
        add(8'hCE,1,1, 0, 1,0,1,1,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);   // JZ -2, taken
        add(8'hCE,1,0, 1, 0,0,0,0,0,0, 3'd0, 0,0, 0,1, 0,0, 2'd0, 0,0);
        add(8'hCE,1,0, 2, 1,1,0,0,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);
        add(8'hCE,0,1, 0, 1,0,1,1,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);   // JZ -2, not taken
        add(8'hCE,0,0, 1, 0,0,0,0,0,0, 3'd0, 0,0, 0,1, 0,0, 2'd0, 0,0);
        add(8'hCE,0,0, 2, 0,0,0,0,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);
        add(8'hE0,0,1, 0, 1,0,1,1,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);   // HLT
        add(8'hE0,0,0, 1, 0,0,0,0,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 0,0);
        add(8'hE0,0,0, 5, 0,0,0,0,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 1,0);
        add(8'hE0,0,1, 5, 0,0,0,0,0,0, 3'd0, 0,0, 0,0, 0,0, 2'd0, 1,0);

        reset = 1'b0; instr = 8'h00; zf = 1'b0; mem_ready = 1'b0; step = 1'b1;
        @(negedge clk);
        check("reset_outs", 32'(outs()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            instr     = vecs[i].instr;
            zf        = vecs[i].zf;
            mem_ready = vecs[i].mr;
            @(negedge clk);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
            @(posedge clk); #1;
        end

        // fetch timeout after WAIT_MAX waiting cycles
        do_reset();
        instr = 8'h10; mem_ready = 1'b0;
        check("post_reset_fault", 32'(fault), 32'd0);
        repeat (14) @(posedge clk);
        #1;
        check("to_wait14_state", 32'(state), 32'd0);
        @(posedge clk); #1;
        check("to_halt_state", 32'(state), 32'd5);
        check("to_halt_flags", 32'({halt, fault, mem_req}), 32'b110);
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("to_sticky", 32'({state, halt, fault}), 32'b101_1_1);

        // mem_ready on the would-be timeout cycle wins
        do_reset();
        mem_ready = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        #1;
        check("edge_ir_we", 32'(ir_we), 32'd1);
        @(posedge clk); #1;
        check("edge_no_fault", 32'({state, fault}), 32'b001_0);

        // reset asserted mid-MEMORY with mem_ready low
        instr = 8'hB3; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_mem_state", 32'({state, mem_req, mem_we}), 32'b011_1_1);
        reset = 1'b0;
        #1;
        check("mid_mem_reset_outs", 32'(outs()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("after_reset_fetch", 32'({state, mem_req, addr_sel}), 32'b000_1_0);

`ifdef CU_SINGLE_STEP_EN
        do_reset();
        instr = 8'h75; mem_ready = 1'b1; step = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        mem_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("step_wait_hold", 32'({state, mem_req, rf_we}), 32'b110_0_0);
        step = 1'b1;
        @(posedge clk); #1;
        check("step_release", 32'({state, mem_req}), 32'b000_1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
